// File: rtl/csa_resolver.sv
// Multi-cycle, chunked carry-propagate adder that resolves a CSA sum/carry pair into binary.
// Defining CSA_RESOLVER_FLAGS_EN adds the res_zero / res_msb result flags.
module csa_resolver #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] sum,
   input  logic [WIDTH-1:0] carry,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             carry_out
`ifdef CSA_RESOLVER_FLAGS_EN
   ,
   output logic                     res_zero,
   output logic [$clog2(WIDTH)-1:0] res_msb
`endif
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int MSBW   = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [WIDTH-1:0] r_sum;
   logic [WIDTH-1:0] r_carry;
   logic             r_creg;
   logic [KW-1:0]    r_k;
   logic [WIDTH-1:0] r_res;
   logic             r_cout;
   logic             w_accept;
   logic             w_lastChunk;
   logic [CHUNK:0]   w_chunkAdd;

   assign w_accept    = in_valid && (r_state == IDLE);
   assign w_lastChunk = (r_state == BUSY) && (r_k == KW'(NCHUNK - 1));

   // The captured operands shift down one chunk per BUSY cycle, so the adder always sees bit 0.
   assign w_chunkAdd = {1'b0, r_sum[CHUNK-1:0]} + {1'b0, r_carry[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, r_creg};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (in_valid)    w_nextState = BUSY;
         BUSY:    if (w_lastChunk) w_nextState = DONE;
         DONE:    if (out_ready)   w_nextState = IDLE;
         default:                  w_nextState = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
   end

   // Result chunks are written in place; chunks not yet reached keep their old contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum   <= '0;
         r_carry <= '0;
         r_creg  <= 1'b0;
         r_k     <= '0;
         r_res   <= '0;
         r_cout  <= 1'b0;
      end else if (w_accept) begin
         r_sum   <= sum;
         r_carry <= carry;
         r_creg  <= cin;
         r_k     <= '0;
      end else if (r_state == BUSY) begin
         r_sum   <= r_sum >> CHUNK;
         r_carry <= r_carry >> CHUNK;
         r_creg  <= w_chunkAdd[CHUNK];
         r_k     <= r_k + 1'b1;
         for (int i = 0; i < NCHUNK; i++) begin
            if (r_k == KW'(i)) begin
               r_res[i*CHUNK +: CHUNK] <= w_chunkAdd[CHUNK-1:0];
            end
         end
         if (w_lastChunk) begin
            r_cout <= w_chunkAdd[CHUNK];
         end
      end
   end

   assign res       = r_res;
   assign carry_out = r_cout;

`ifdef CSA_RESOLVER_FLAGS_EN
   logic            r_zero;
   logic [MSBW-1:0] r_msb;
   logic [MSBW-1:0] w_chunkMsb;
   logic [MSBW-1:0] w_msbCand;
   logic            w_chunkNonZero;

   always_comb begin
      w_chunkMsb = '0;
      for (int i = 0; i < CHUNK; i++) begin
         if (w_chunkAdd[i]) begin
            w_chunkMsb = MSBW'(i);
         end
      end
   end

   assign w_chunkNonZero = (w_chunkAdd[CHUNK-1:0] != '0);
   assign w_msbCand      = MSBW'(int'(r_k) * CHUNK + int'(w_chunkMsb));

   // Chunks arrive low to high, so the last non-zero chunk seen owns the most significant bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_zero <= 1'b1;
         r_msb  <= '0;
      end else if (w_accept) begin
         r_zero <= 1'b1;
         r_msb  <= '0;
      end else if ((r_state == BUSY) && w_chunkNonZero) begin
         r_zero <= 1'b0;
         r_msb  <= w_msbCand;
      end
   end

   assign res_zero = r_zero;
   assign res_msb  = r_msb;
`else
   logic [MSBW-1:0] w_unusedMsbw;
   assign w_unusedMsbw = '0;
`endif

endmodule

// File: tb/tb_csa_resolver.sv
// Self-checking bench for csa_resolver: vector table, handshake corner cases and random traffic.
module tb_csa_resolver;

   localparam int WIDTH  = 64;
   localparam int CHUNK  = 16;
   localparam int NCHUNK = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] carry;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] res;
   logic             carry_out;
`ifdef CSA_RESOLVER_FLAGS_EN
   logic             res_zero;
   logic [5:0]       res_msb;
`endif

   csa_resolver #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum       (sum),
      .carry     (carry),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .carry_out (carry_out)
`ifdef CSA_RESOLVER_FLAGS_EN
      ,
      .res_zero  (res_zero),
      .res_msb   (res_msb)
`endif
   );

   always #5 clk = ~clk;

   int nChecks    = 0;
   int nFails     = 0;
   int cycleCount = 0;

   always @(posedge clk) cycleCount++;

   typedef struct {
      logic [63:0] s;
      logic [63:0] c;
      logic        ci;
      logic [63:0] expRes;
      logic        expCout;
   } vec_t;

   vec_t vecs[8];

   // Reference: the whole 65-bit sum in one step, no chunking.
   function automatic logic [64:0] modelAdd(input logic [63:0] s, input logic [63:0] c,
                                            input logic ci);
      return {1'b0, s} + {1'b0, c} + 65'(ci);
   endfunction

   function automatic int modelMsb(input logic [63:0] v);
      int m = 0;
      for (int i = 0; i < 64; i++) begin
         if (v[i]) m = i;
      end
      return m;
   endfunction

   task automatic checkOutput(input string name, input logic [64:0] actual,
                              input logic [64:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
      end
   endtask

   // Waits for in_ready, then presents the operand across one accepting edge.
   task automatic applyStimulus(input logic [63:0] s, input logic [63:0] c, input logic ci);
      int waitCnt = 0;
      while (!in_ready && waitCnt < 100) begin
         @(posedge clk); #1;
         waitCnt++;
      end
      checkOutput("accept_ready", 65'(in_ready), 65'(1));
      sum      = s;
      carry    = c;
      cin      = ci;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      sum      = {$urandom, $urandom};
      carry    = {$urandom, $urandom};
      cin      = 1'($urandom_range(0, 1));
   endtask

   task automatic waitResult(input string name, input logic [64:0] expected, input int expLat);
      int lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput({name, "_latency"}, 65'(lat), 65'(expLat));
      checkOutput({name, "_result"}, {carry_out, res}, expected);
`ifdef CSA_RESOLVER_FLAGS_EN
      checkOutput({name, "_zero"}, 65'(res_zero), 65'(expected[63:0] == 64'h0));
      if (expected[63:0] != 64'h0) begin
         checkOutput({name, "_msb"}, 65'(res_msb), 65'(modelMsb(expected[63:0])));
      end
`endif
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, required finish before 500000ns");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [64:0] expA;
      logic [64:0] expB;
      logic [63:0] bSum;
      logic [63:0] bCarry;
      logic        bCin;
      int          spurious;
      int          prevAccept;
      int          thisAccept;

      vecs[0] = '{64'h0000_0000_0000_0005, 64'h0000_0000_0000_0003, 1'b0, 64'h0000_0000_0000_0008, 1'b0};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0000, 1'b1};
      vecs[2] = '{64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 64'h0000_0000_0001_0000, 1'b0};
      vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
      vecs[4] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      vecs[5] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 64'h0000_0000_0000_0000, 1'b1};
      vecs[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0000, 1'b1};
      vecs[7] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 64'h0001_0000_0001_0000, 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      sum       = '0;
      carry     = '0;
      cin       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_in_ready", 65'(in_ready), 65'(1));
      checkOutput("reset_out_valid", 65'(out_valid), 65'(0));
      checkOutput("reset_result", {carry_out, res}, 65'(0));
`ifdef CSA_RESOLVER_FLAGS_EN
      checkOutput("reset_zero", 65'(res_zero), 65'(1));
      checkOutput("reset_msb", 65'(res_msb), 65'(0));
`endif
      rst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] vector table");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].s, vecs[i].c, vecs[i].ci);
         waitResult($sformatf("vec%0d", i), {vecs[i].expCout, vecs[i].expRes}, NCHUNK);
         consume();
      end

      $display("[TB] backpressure");
      expA = modelAdd(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
      applyStimulus(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
      waitResult("bp_first", expA, NCHUNK);
      bSum     = {$urandom, $urandom};
      bCarry   = {$urandom, $urandom};
      bCin     = 1'($urandom_range(0, 1));
      expB     = modelAdd(bSum, bCarry, bCin);
      sum      = bSum;
      carry    = bCarry;
      cin      = bCin;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checkOutput("bp_hold_result", {carry_out, res}, expA);
         checkOutput("bp_hold_in_ready", 65'(in_ready), 65'(0));
         checkOutput("bp_hold_out_valid", 65'(out_valid), 65'(1));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput("bp_idle_in_ready", 65'(in_ready), 65'(1));
      checkOutput("bp_idle_out_valid", 65'(out_valid), 65'(0));
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput("bp_second_accepted", 65'(in_ready), 65'(0));
      waitResult("bp_second", expB, NCHUNK);
      consume();

      $display("[TB] reset during BUSY");
      applyStimulus(64'h1234, 64'h1, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("midrst_out_valid", 65'(out_valid), 65'(0));
      checkOutput("midrst_in_ready", 65'(in_ready), 65'(1));
      checkOutput("midrst_result", {carry_out, res}, 65'(0));
      spurious = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid) spurious++;
      end
      checkOutput("midrst_spurious_valid", 65'(spurious), 65'(0));

      $display("[TB] random back-to-back");
      out_ready  = 1'b1;
      prevAccept = 0;
      for (int i = 0; i < 1000; i++) begin
         logic [63:0] rs;
         logic [63:0] rc;
         logic        rci;
         rs  = {$urandom, $urandom};
         rc  = {$urandom, $urandom};
         rci = 1'($urandom_range(0, 1));
         applyStimulus(rs, rc, rci);
         thisAccept = cycleCount;
         if (i > 0) begin
            checkOutput("rand_period", 65'(thisAccept - prevAccept), 65'(NCHUNK + 2));
         end
         prevAccept = thisAccept;
         waitResult("rand", modelAdd(rs, rc, rci), NCHUNK);
      end
      out_ready = 1'b0;
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
